// File: rtl/kmer_stream_packer_pkg.sv
// kmer_pkg: shared constants and types for the k-mer stream packer.
//   K          k-mer length in bases
//   READ_LEN   bases per read
//   KMER_W     bits per k-mer (2 bits per base)
//   NUM_KMERS  overlapping k-mers per read
//   IDX_W      width of the base counter
package kmer_pkg;

  localparam int K         = 16;
  localparam int READ_LEN  = 64;
  localparam int KMER_W    = 2 * K;
  localparam int NUM_KMERS = READ_LEN - K + 1;
  localparam int IDX_W     = $clog2(READ_LEN);

  typedef enum logic [1:0] {
    A = 2'b00,
    C = 2'b01,
    G = 2'b10,
    T = 2'b11
  } base_t;

  typedef logic [KMER_W-1:0] kmer_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } packer_state_t;

endpackage

// File: rtl/kmer_window_shift.sv
// kmer_window_shift: 2*K-bit shift register holding the last K bases.
// Ports:
//   clk, rstN  clock and asynchronous active-low reset
//   shiftEn    shift one base in at the rising edge
//   clear      synchronous clear (wins over shiftEn)
//   base       incoming nucleotide
//   winNext    combinational value the window takes on a shift
module kmer_window_shift
  import kmer_pkg::*;
(
  input  logic  clk,
  input  logic  rstN,
  input  logic  shiftEn,
  input  logic  clear,
  input  base_t base,
  output kmer_t winNext
);

  kmer_t win;

  // Oldest base leaves from the top; newest enters in bits [1:0].
  assign winNext = {win[KMER_W-3:0], base};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      win <= '0;
    end else if (clear) begin
      win <= '0;
    end else if (shiftEn) begin
      win <= winNext;
    end
  end

endmodule

// File: rtl/kmer_stream_packer.sv
// kmer_stream_packer: turns a serial stream of 2-bit bases into the full
// array of overlapping k-mers for one read.
// Ports:
//   clk, rstN   clock and asynchronous active-low reset
//   baseValid   base/baseLast valid
//   baseReady   block accepts a base (COLLECT only)
//   base        nucleotide A=00 C=01 G=10 T=11
//   baseLast    final base of the read
//   kmersOut    k-mer j = bases j..j+K-1, base j in the top bits
//   kmersValid  kmersOut holds a complete read (HOLD)
//   kmersAck    consumer took kmersOut; leaves HOLD
//   lenError    one-cycle pulse: read length wrong, read discarded
module kmer_stream_packer
  import kmer_pkg::*;
(
  input  logic                               clk,
  input  logic                               rstN,
  input  logic                               baseValid,
  output logic                               baseReady,
  input  logic [1:0]                         base,
  input  logic                               baseLast,
  output logic [NUM_KMERS-1:0][KMER_W-1:0]   kmersOut,
  output logic                               kmersValid,
  input  logic                               kmersAck,
  output logic                               lenError
);

  packer_state_t    state;
  logic [IDX_W-1:0] idx;
  kmer_t            win_next;

  // Slot NUM_KMERS-1 is never stored here: on completion it comes
  // straight from win_next into the output register.
  kmer_t            work [NUM_KMERS-1];

  logic             xfer;
  logic             at_last;
  logic             len_err;
  logic             done;
  logic             slot_en;
  logic [IDX_W-1:0] slot;

  assign baseReady = rstN && (state == COLLECT);
  assign xfer      = baseValid && baseReady;
  assign at_last   = (idx == IDX_W'(READ_LEN - 1));
  // Length error: baseLast disagrees with the position in the read.
  assign len_err   = xfer && (baseLast != at_last);
  assign done      = xfer && baseLast && at_last;
  assign slot      = idx - IDX_W'(K - 1);
  assign slot_en   = xfer && (idx >= IDX_W'(K - 1)) && !at_last;

  // kmersValid is a decode of the state flop, so it is registered.
  assign kmersValid = (state == HOLD);

  kmer_window_shift u_window (
    .clk     (clk),
    .rstN    (rstN),
    .shiftEn (xfer),
    .clear   (len_err),
    .base    (base_t'(base)),
    .winNext (win_next)
  );

  // NOTE: the working array has no reset; every slot is rewritten before it
  // is copied out, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (slot_en) begin
      work[slot] <= win_next;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= COLLECT;
      idx      <= '0;
      lenError <= 1'b0;
    end else begin
      lenError <= len_err;
      if (xfer) begin
        idx <= (done || len_err) ? '0 : idx + IDX_W'(1);
      end
      case (state)
        COLLECT: if (done)     state <= HOLD;
        HOLD:    if (kmersAck) state <= COLLECT;
        default:               state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      kmersOut <= '0;
    end else if (done) begin
      for (int j = 0; j < NUM_KMERS - 1; j++) begin
        kmersOut[j] <= work[j];
      end
      kmersOut[NUM_KMERS-1] <= win_next;
    end
  end

endmodule

// File: tb/tb_kmer_stream_packer.sv
// tb_kmer_stream_packer: directed, table-driven bench for kmer_stream_packer.
module tb_kmer_stream_packer;
  import kmer_pkg::*;

  localparam int KIND_T    = 0;
  localparam int KIND_ACGT = 1;

  logic                             clk;
  logic                             rstN;
  logic                             baseValid;
  logic                             baseReady;
  logic [1:0]                       base;
  logic                             baseLast;
  logic [NUM_KMERS-1:0][KMER_W-1:0] kmersOut;
  logic                             kmersValid;
  logic                             kmersAck;
  logic                             lenError;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses   = 0;
  int valid_cycles = 0;

  kmer_stream_packer dut (
    .clk        (clk),
    .rstN       (rstN),
    .baseValid  (baseValid),
    .baseReady  (baseReady),
    .base       (base),
    .baseLast   (baseLast),
    .kmersOut   (kmersOut),
    .kmersValid (kmersValid),
    .kmersAck   (kmersAck),
    .lenError   (lenError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstN && lenError)   err_pulses++;
    if (rstN && kmersValid) valid_cycles++;
  end

  typedef struct {
    int              kind;
    int              n;
    logic            last;
    logic            bubbles;
    logic            exp_valid;
    logic            exp_err;
    logic [3:0][31:0] exp;   // expected kmersOut[j] for j%4 = 0..3
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the transferring edge.
  task automatic send_base(input logic [1:0] b, input logic last);
    int waited;
    waited = 0;
    baseValid = 1'b1;
    base      = b;
    baseLast  = last;
    while (!baseReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("ready_timeout", {31'd0, baseReady}, 32'd1);
    @(negedge clk);
    baseValid = 1'b0;
    baseLast  = 1'b0;
  endtask

  task automatic send_read(input int kind, input int n, input logic last, input logic bubbles);
    logic [1:0] b;
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      b = (kind == KIND_T) ? 2'b11 : 2'(i % 4);
      send_base(b, last && (i == n - 1));
    end
  endtask

  task automatic check_slots(input string name, input logic [3:0][31:0] exp);
    for (int j = 0; j < NUM_KMERS; j++) begin
      check($sformatf("%s_slot%0d", name, j), kmersOut[j], exp[j % 4]);
    end
  endtask

  task automatic ack_and_check(input string name);
    kmersAck = 1'b1;
    @(negedge clk);
    kmersAck = 1'b0;
    check({name, "_valid_after_ack"}, {31'd0, kmersValid}, 32'd0);
    check({name, "_ready_after_ack"}, {31'd0, baseReady}, 32'd1);
  endtask

  logic [3:0][31:0] all_t, acgt, zeros;
  logic [NUM_KMERS-1:0][KMER_W-1:0] snap;
  int e0, v0;

  initial begin
    all_t = {4{32'hFFFF_FFFF}};
    acgt  = {32'hC6C6_C6C6, 32'hB1B1_B1B1, 32'h6C6C_6C6C, 32'h1B1B_1B1B};
    zeros = '0;

    //            kind       n   last bub  valid err  expected k-mers
    vecs[0] = '{KIND_T,    64, 1'b1, 1'b0, 1'b1, 1'b0, all_t};
    vecs[1] = '{KIND_ACGT, 64, 1'b1, 1'b0, 1'b1, 1'b0, acgt};
    vecs[2] = '{KIND_ACGT, 64, 1'b0, 1'b0, 1'b0, 1'b1, acgt};   // long read
    vecs[3] = '{KIND_T,    64, 1'b1, 1'b0, 1'b1, 1'b0, all_t};
    vecs[4] = '{KIND_ACGT, 64, 1'b1, 1'b1, 1'b1, 1'b0, acgt};

    rstN = 1'b0; baseValid = 1'b0; base = 2'b00; baseLast = 1'b0; kmersAck = 1'b0;
    idle(3);
    check("rst_valid", {31'd0, kmersValid}, 32'd0);
    check("rst_lenerr", {31'd0, lenError}, 32'd0);
    check("rst_ready", {31'd0, baseReady}, 32'd0);
    check_slots("rst", zeros);
    rstN = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, baseReady}, 32'd1);

    // Short read straight out of reset: error pulse, output stays zero.
    e0 = err_pulses; v0 = valid_cycles;
    send_read(KIND_T, 11, 1'b1, 1'b0);
    check("short_lenerr", {31'd0, lenError}, 32'd1);
    check("short_valid", {31'd0, kmersValid}, 32'd0);
    idle(2);
    check("short_err_pulses", 32'(err_pulses - e0), 32'd1);
    check("short_valid_cycles", 32'(valid_cycles - v0), 32'd0);
    check_slots("short", zeros);

    foreach (vecs[v]) begin
      e0 = err_pulses; v0 = valid_cycles;
      send_read(vecs[v].kind, vecs[v].n, vecs[v].last, vecs[v].bubbles);
      check($sformatf("v%0d_valid", v), {31'd0, kmersValid}, {31'd0, vecs[v].exp_valid});
      check($sformatf("v%0d_lenerr", v), {31'd0, lenError}, {31'd0, vecs[v].exp_err});
      check_slots($sformatf("v%0d", v), vecs[v].exp);
      if (vecs[v].exp_valid) ack_and_check($sformatf("v%0d", v));
      idle(2);
      check($sformatf("v%0d_err_pulses", v), 32'(err_pulses - e0), {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_valid_cycles", v), 32'(valid_cycles - v0), {31'd0, vecs[v].exp_valid});
    end

    // Backpressure: hold off the ack with bases pending.
    send_read(KIND_T, 64, 1'b1, 1'b0);
    snap = kmersOut;
    baseValid = 1'b1; base = 2'b00; baseLast = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_ready%0d", c), {31'd0, baseReady}, 32'd0);
      check($sformatf("bp_valid%0d", c), {31'd0, kmersValid}, 32'd1);
      check($sformatf("bp_stable%0d", c), {31'd0, kmersOut == snap}, 32'd1);
    end
    baseValid = 1'b0;
    ack_and_check("bp");
    // Nothing was consumed during HOLD, so a full read must land cleanly.
    e0 = err_pulses;
    send_read(KIND_ACGT, 64, 1'b1, 1'b0);
    check("bp_next_valid", {31'd0, kmersValid}, 32'd1);
    check_slots("bp_next", acgt);
    ack_and_check("bp_next");
    idle(2);
    check("bp_next_err_pulses", 32'(err_pulses - e0), 32'd0);

    // Reset mid-read.
    send_read(KIND_T, 30, 1'b0, 1'b0);
    #2 rstN = 1'b0;
    #1;
    check("midrst_valid", {31'd0, kmersValid}, 32'd0);
    check("midrst_ready", {31'd0, baseReady}, 32'd0);
    check("midrst_lenerr", {31'd0, lenError}, 32'd0);
    check_slots("midrst", zeros);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Reset while holding a completed read.
    send_read(KIND_ACGT, 64, 1'b1, 1'b0);
    check("hold_valid", {31'd0, kmersValid}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("holdrst_valid", {31'd0, kmersValid}, 32'd0);
    check_slots("holdrst", zeros);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // ACGT read with random bubbles after reset.
    e0 = err_pulses;
    send_read(KIND_ACGT, 64, 1'b1, 1'b1);
    check("bub_valid", {31'd0, kmersValid}, 32'd1);
    check_slots("bub", acgt);
    ack_and_check("bub");
    idle(2);
    check("bub_err_pulses", 32'(err_pulses - e0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
